// File: rtl/rr_onehot_arbiter_pkg.sv
// Shared types and the round-robin search helper for rr_onehot_arbiter.
// The search is sized for the largest supported N and narrowed by the caller.
package rr_onehot_arbiter_pkg;

    localparam int unsigned MAX_N    = 64;
    localparam int unsigned MAX_IDXW = 6;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic                found;
        logic [MAX_IDXW-1:0] idx;
    } pick_t;

    // First set bit of req at or after ptr, wrapping at n (only the low n bits are considered).
    function automatic pick_t rr_pick(
        input logic [MAX_N-1:0]    req,
        input logic [MAX_IDXW-1:0] ptr,
        input int unsigned         n
    );
        pick_t       res;
        int unsigned j;
        res = '0;
        for (int unsigned i = 0; i < MAX_N; i++) begin
            j = 32'(ptr) + i;
            if (j >= n) begin
                j = j - n;
            end
            if ((i < n) && !res.found && req[j[MAX_IDXW-1:0]]) begin
                res.found = 1'b1;
                res.idx   = MAX_IDXW'(j);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_onehot_arbiter_bin_to_onehot.sv
// Binary index to one-hot decoder used for the arbiter's one-hot grant.
module rr_onehot_arbiter_bin_to_onehot #(
    parameter int unsigned N    = 8,
    parameter int unsigned IDXW = $clog2(N)
) (
    input  logic [IDXW-1:0] i_bin,
    output logic [N-1:0]    o_oh
);

    always_comb begin
        o_oh = N'(1) << i_bin;
    end

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter: one owner at a time, held until done, with binary and
// one-hot grant outputs that are both registered.
module rr_onehot_arbiter
    import rr_onehot_arbiter_pkg::*;
#(
    parameter  int unsigned N    = 8,
    localparam int unsigned IDXW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic            done,
    output logic            gnt_valid,
    output logic [IDXW-1:0] gnt_idx,
    output logic [N-1:0]    gnt_oh
);

    arb_state_t      r_state;
    arb_state_t      w_state_nxt;
    logic [IDXW-1:0] r_ptr;
    logic [IDXW-1:0] w_ptr_nxt;
    logic [IDXW-1:0] r_gnt_idx;
    logic [IDXW-1:0] w_idx_nxt;
    logic            r_gnt_valid;
    logic            w_valid_nxt;
    logic [N-1:0]    r_gnt_oh;
    logic [N-1:0]    w_oh_raw;
    logic [N-1:0]    w_oh_nxt;
    logic [N-1:0]    w_cand;
    pick_t           w_pick;
    logic            w_win_last;
    logic [IDXW-1:0] w_win;
    logic [IDXW-1:0] w_win_inc;

    // While busy the owner is excluded so a release hands off to someone else.
    always_comb begin
        w_cand     = (r_state == BUSY) ? (req & ~r_gnt_oh) : req;
        w_pick     = rr_pick(MAX_N'(w_cand), MAX_IDXW'(r_ptr), N);
        w_win      = IDXW'(w_pick.idx);
        w_win_last = (w_pick.idx == MAX_IDXW'(N - 1));
        w_win_inc  = w_win_last ? '0 : (w_win + IDXW'(1));
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_gnt_idx;
        w_ptr_nxt   = r_ptr;
        w_valid_nxt = r_gnt_valid;
        unique case (r_state)
            IDLE: begin
                if (w_pick.found) begin
                    w_state_nxt = BUSY;
                    w_idx_nxt   = w_win;
                    w_ptr_nxt   = w_win_inc;
                    w_valid_nxt = 1'b1;
                end
            end
            BUSY: begin
                if (done) begin
                    if (w_pick.found) begin
                        w_idx_nxt = w_win;
                        w_ptr_nxt = w_win_inc;
                    end else begin
                        w_state_nxt = IDLE;
                        w_valid_nxt = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    rr_onehot_arbiter_bin_to_onehot #(
        .N    (N),
        .IDXW (IDXW)
    ) u_bin_to_onehot (
        .i_bin (w_idx_nxt),
        .o_oh  (w_oh_raw)
    );

    always_comb begin
        w_oh_nxt = w_oh_raw & {N{w_valid_nxt}};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_gnt_idx   <= '0;
            r_gnt_valid <= 1'b0;
            r_gnt_oh    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_gnt_idx   <= w_idx_nxt;
            r_gnt_valid <= w_valid_nxt;
            r_gnt_oh    <= w_oh_nxt;
        end
    end

    assign gnt_valid = r_gnt_valid;
    assign gnt_idx   = r_gnt_idx;
    assign gnt_oh    = r_gnt_oh;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Bench for rr_onehot_arbiter: directed scenarios followed by random traffic,
// all compared against a behavioural round-robin model.
module tb_rr_onehot_arbiter;

    localparam int unsigned N    = 8;
    localparam int unsigned IDXW = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic            done;
    logic            gnt_valid;
    logic [IDXW-1:0] gnt_idx;
    logic [N-1:0]    gnt_oh;

    int n_chk  = 0;
    int n_pass = 0;

    bit m_valid;
    int m_idx;
    int m_ptr;
    int starve [N];
    int max_starve;

    always #5 clk = ~clk;

    rr_onehot_arbiter #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .gnt_oh    (gnt_oh)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    endtask

    // Lowest-distance requester starting from 'start', wrapping modulo N.
    function automatic int pick(input logic [N-1:0] r, input int start);
        for (int k = 0; k < int'(N); k++) begin
            if (r[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_idx   = 0;
        m_ptr   = 0;
        for (int i = 0; i < int'(N); i++) starve[i] = 0;
    endtask

    task automatic note_grant(input int w);
        for (int i = 0; i < int'(N); i++) begin
            if (i != w && req[i]) begin
                starve[i]++;
                if (starve[i] > max_starve) max_starve = starve[i];
            end
        end
        starve[w] = 0;
        m_idx     = w;
        m_ptr     = (w + 1) % N;
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        int w;
        logic [N-1:0] masked;
        for (int i = 0; i < int'(N); i++) if (!req[i]) starve[i] = 0;
        if (!m_valid) begin
            w = pick(req, m_ptr);
            if (w >= 0) begin
                m_valid = 1'b1;
                note_grant(w);
            end
        end else if (done) begin
            masked        = req;
            masked[m_idx] = 1'b0;
            w = pick(masked, m_ptr);
            if (w >= 0) note_grant(w);
            else m_valid = 1'b0;
        end
    endtask

    task automatic check_outs(input string tag);
        logic [63:0] exp_oh;
        logic [63:0] shape;
        exp_oh = m_valid ? (64'd1 << m_idx) : 64'd0;
        shape  = gnt_valid ? (64'd1 << gnt_idx) : 64'd0;
        chk({tag, "_valid"}, 64'(gnt_valid), 64'(m_valid));
        chk({tag, "_idx"},   64'(gnt_idx),   64'(m_idx));
        chk({tag, "_oh"},    64'(gnt_oh),    exp_oh);
        chk({tag, "_shape"}, 64'(gnt_oh),    shape);
    endtask

    // Called at a falling edge: drive inputs, step model, check at next falling edge.
    task automatic cycle(input string tag, input logic [N-1:0] r, input logic d);
        req  = r;
        done = d;
        model_step();
        @(negedge clk);
        check_outs(tag);
    endtask

    initial begin
        logic [N-1:0] r;
        logic         d;
        rst        = 1'b1;
        req        = '0;
        done       = 1'b0;
        max_starve = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outs("reset");
        rst = 1'b0;

        // Single request, then release to idle.
        cycle("single_gnt", 8'h10, 1'b0);
        chk("single_idx_const", 64'(gnt_idx), 64'd4);
        chk("single_oh_const",  64'(gnt_oh),  64'h10);
        cycle("single_rel", 8'h00, 1'b1);
        chk("single_rel_valid", 64'(gnt_valid), 64'd0);

        // Reset while a grant is active clears outputs before the next edge.
        cycle("pre_reset", 8'h10, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_valid", 64'(gnt_valid), 64'd0);
        chk("rst_async_oh",    64'(gnt_oh),    64'd0);
        chk("rst_async_idx",   64'(gnt_idx),   64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Full rotation from pointer 0.
        cycle("rot", 8'hFF, 1'b0);
        chk("rot_first_idx", 64'(gnt_idx), 64'd0);
        for (int k = 1; k <= int'(N); k++) begin
            cycle("rot", 8'hFF, 1'b1);
            chk("rot_seq_idx", 64'(gnt_idx), 64'(k % N));
            chk("rot_seq_oh",  64'(gnt_oh),  64'd1 << (k % N));
        end
        cycle("rot_end", 8'h00, 1'b1);

        // Pointer parked at 6, then wrap and skip.
        cycle("park", 8'h20, 1'b0);
        cycle("park_rel", 8'h00, 1'b1);
        cycle("wrap0", 8'h05, 1'b0);
        chk("wrap_first_idx", 64'(gnt_idx), 64'd0);
        cycle("wrap2", 8'h05, 1'b1);
        chk("wrap_second_idx", 64'(gnt_idx), 64'd2);
        cycle("wrap0b", 8'h05, 1'b1);
        chk("wrap_third_idx", 64'(gnt_idx), 64'd0);
        cycle("wrap_end", 8'h00, 1'b1);

        // Owner 3 keeps the grant through request changes until done.
        cycle("hold_gnt", 8'h08, 1'b0);
        chk("hold_start_idx", 64'(gnt_idx), 64'd3);
        for (int k = 0; k < 10; k++) begin
            cycle("hold", 8'hF7, 1'b0);
            chk("hold_idx", 64'(gnt_idx), 64'd3);
        end
        cycle("hold_rel", 8'hF7, 1'b1);
        chk("hold_next_idx",   64'(gnt_idx),   64'd4);
        chk("hold_next_valid", 64'(gnt_valid), 64'd1);

        // Random traffic: requests stay up until their owner releases.
        r = 8'hF7;
        for (int c = 0; c < 3000; c++) begin
            d = m_valid && ($urandom_range(0, 2) == 0);
            if (!m_valid && ($urandom_range(0, 7) == 0)) d = 1'b1;
            for (int i = 0; i < int'(N); i++) begin
                if (!r[i] && ($urandom_range(0, 3) == 0)) r[i] = 1'b1;
                if (d && m_valid && i == m_idx && ($urandom_range(0, 1) == 0)) r[i] = 1'b0;
            end
            cycle("rand", r, d);
        end
        chk("starve_bound", 64'(max_starve <= int'(N) - 1), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
